// File: rtl/feistel_crypt_core_if.sv
// rtl/feistel_crypt_core_if.sv - memory-mapped register bus for the Feistel cipher core
interface feistel_crypt_core_if;
  logic [3:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, write, writedata, read,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, write, writedata, read,
    output readdata, waitrequest
  );
endinterface

// File: rtl/feistel_crypt_core.sv
// rtl/feistel_crypt_core.sv - 128-bit Feistel encrypt/decrypt accelerator, one round per two cycles
module sbox (
  input  logic [31:0] inText,
  output logic [31:0] outText
);
  function automatic logic [3:0] sb4(input logic [3:0] v);
    case (v)
      4'h0: sb4 = 4'hC;  4'h1: sb4 = 4'h5;  4'h2: sb4 = 4'h6;  4'h3: sb4 = 4'hB;
      4'h4: sb4 = 4'h9;  4'h5: sb4 = 4'h0;  4'h6: sb4 = 4'hA;  4'h7: sb4 = 4'hD;
      4'h8: sb4 = 4'h3;  4'h9: sb4 = 4'hE;  4'hA: sb4 = 4'hF;  4'hB: sb4 = 4'h8;
      4'hC: sb4 = 4'h4;  4'hD: sb4 = 4'h7;  4'hE: sb4 = 4'h1;  default: sb4 = 4'h2;
    endcase
  endfunction

  always_comb begin
    outText = '0;
    for (int n = 0; n < 8; n++) outText[4*n +: 4] = sb4(inText[4*n +: 4]);
  end
endmodule

module feistel_crypt_core #(
  parameter int         NUM_ROUNDS = 12,
  parameter logic [6:0] RC_INIT    = 7'h5A,
  parameter int         ROT        = 21
) (
  input  logic                  clk,
  input  logic                  reset,
  feistel_crypt_core_if.slave   bus,
  output logic                  irq
);
  typedef enum logic [1:0] {IDLE, KEYEXP, SUB, MIX} state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);
  localparam logic [3:0] LAST_KEXP  = 4'(NUM_ROUNDS - 2);

  state_t       state;
  logic [127:0] text;
  logic [127:0] key;
  logic [127:0] rk;
  logic [6:0]   rc;
  logic [3:0]   cnt;
  logic [63:0]  s_reg;
  logic         mode;
  logic         busy;
  logic         done;

  function automatic logic [63:0] sw(input logic [63:0] x);
    sw = {x[47:32], x[63:48], x[15:0], x[31:16]};
  endfunction

  function automatic logic [127:0] kstep(input logic [127:0] r);
    logic [63:0] t;
    t = sw(r[63:0]);
    kstep = {t, t ^ r[127:64]};
  endfunction

  function automatic logic [127:0] kinv(input logic [127:0] r);
    kinv = {r[63:0] ^ r[127:64], sw(r[127:64])};
  endfunction

  function automatic logic [6:0] rc_next(input logic [6:0] c);
    rc_next = {c[5:0], c[6] ^ c[5]};
  endfunction

  function automatic logic [6:0] rc_prev(input logic [6:0] n);
    rc_prev = {n[0] ^ n[6], n[6:1]};
  endfunction

  // Encrypt substitutes the left half, decrypt the right half.
  logic [63:0] half_sel;
  logic [63:0] sbox_in;
  logic [31:0] s_hi;
  logic [31:0] s_lo;
  logic [63:0] f_out;

  assign half_sel = mode ? text[63:0] : text[127:64];
  assign sbox_in  = half_sel ^ rk[127:64];
  assign f_out    = ((s_reg << ROT) | (s_reg >> (64 - ROT))) ^ rk[63:0] ^ ({57'b0, rc} << 14);

  sbox u_sbox_hi (.inText(sbox_in[63:32]), .outText(s_hi));
  sbox u_sbox_lo (.inText(sbox_in[31:0]),  .outText(s_lo));

  logic wr_hit;

  assign bus.waitrequest = busy & (bus.read | bus.write) & (bus.address != 4'd9);
  assign wr_hit          = bus.write & ~bus.waitrequest;
  assign irq             = done;

  always_comb begin
    bus.readdata = '0;
    if (bus.read) begin
      if (bus.address[3:2] == 2'b00)
        bus.readdata = text[{bus.address[1:0], 5'b0} +: 32];
      else if (bus.address == 4'd9)
        bus.readdata = {30'b0, done, busy};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      text  <= '0;
      key   <= '0;
      rk    <= '0;
      rc    <= '0;
      cnt   <= '0;
      s_reg <= '0;
      mode  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (wr_hit) begin
            if (bus.address[3:2] == 2'b00)
              text[{bus.address[1:0], 5'b0} +: 32] <= bus.writedata;
            else if (bus.address[3:2] == 2'b01)
              key[{bus.address[1:0], 5'b0} +: 32] <= bus.writedata;
            else if (bus.address == 4'd8) begin
              if (bus.writedata[2]) done <= 1'b0;
              if (bus.writedata[0]) begin
                busy  <= 1'b1;
                done  <= 1'b0;
                mode  <= bus.writedata[1];
                rk    <= kstep(key);
                rc    <= RC_INIT;
                cnt   <= '0;
                state <= (bus.writedata[1] && NUM_ROUNDS > 1) ? KEYEXP : SUB;
              end
            end
          end
        end
        // Decrypt walks the schedule forward to the last round key first.
        KEYEXP: begin
          rk <= kstep(rk);
          rc <= rc_next(rc);
          if (cnt == LAST_KEXP) begin
            cnt   <= '0;
            state <= SUB;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        SUB: begin
          s_reg <= {s_hi, s_lo};
          state <= MIX;
        end
        MIX: begin
          if (mode) begin
            text <= {text[63:0], text[127:64] ^ f_out};
            rk   <= kinv(rk);
            rc   <= rc_prev(rc);
          end else begin
            text <= {text[63:0] ^ f_out, text[127:64]};
            rk   <= kstep(rk);
            rc   <= rc_next(rc);
          end
          if (cnt == LAST_ROUND) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt   <= cnt + 4'd1;
            state <= SUB;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_feistel_crypt_core.sv
// tb/tb_feistel_crypt_core.sv - directed bench for feistel_crypt_core (R=12 and R=1 builds)
module tb_feistel_crypt_core;
  localparam logic [6:0]   RCI = 7'h5A;
  localparam logic [127:0] P   = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] K   = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] P2  = 128'hA5A5A5A5_00000001_DEADBEEF_CAFEF00D;

  logic clk = 1'b0;
  logic reset;
  logic irq0, irq1;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  feistel_crypt_core_if b0();
  feistel_crypt_core_if b1();

  feistel_crypt_core dut0 (.clk(clk), .reset(reset), .bus(b0), .irq(irq0));
  feistel_crypt_core #(.NUM_ROUNDS(1), .RC_INIT(7'h5A), .ROT(1)) dut1 (.clk(clk), .reset(reset), .bus(b1), .irq(irq1));

  // ---------------- reference model ----------------
  function automatic logic [3:0] sb4(input logic [3:0] v);
    logic [3:0] t [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    return t[v];
  endfunction

  function automatic logic [31:0] sbox32(input logic [31:0] x);
    logic [31:0] y;
    for (int n = 0; n < 8; n++) y[4*n +: 4] = sb4(x[4*n +: 4]);
    return y;
  endfunction

  function automatic logic [63:0] swm(input logic [63:0] x);
    return {x[47:32], x[63:48], x[15:0], x[31:16]};
  endfunction

  function automatic logic [127:0] kst(input logic [127:0] r);
    logic [63:0] t;
    t = swm(r[63:0]);
    return {t, t ^ r[127:64]};
  endfunction

  function automatic logic [6:0] rcn(input logic [6:0] c);
    return {c[5:0], c[6] ^ c[5]};
  endfunction

  function automatic logic [63:0] ff(input logic [63:0] x, input logic [127:0] r, input logic [6:0] c, input int rot);
    logic [63:0] y, s;
    y = x ^ r[127:64];
    s = {sbox32(y[63:32]), sbox32(y[31:0])};
    return ((s << rot) | (s >> (64 - rot))) ^ r[63:0] ^ ({57'b0, c} << 14);
  endfunction

  function automatic logic [127:0] enc_model(input logic [127:0] p, input logic [127:0] k, input int nr, input int rot);
    logic [63:0]  l, r, f;
    logic [127:0] rk;
    logic [6:0]   c;
    l = p[127:64]; r = p[63:0]; rk = k; c = RCI;
    for (int i = 0; i < nr; i++) begin
      rk = kst(rk);
      f  = ff(l, rk, c, rot);
      {l, r} = {r ^ f, l};
      c  = rcn(c);
    end
    return {l, r};
  endfunction

  // ---------------- bus helpers ----------------
  task automatic drive(input int sel, input logic [3:0] a, input logic w, input logic r, input logic [31:0] d);
    if (sel == 0) begin
      b0.address = a; b0.write = w; b0.read = r; b0.writedata = d;
    end else begin
      b1.address = a; b1.write = w; b1.read = r; b1.writedata = d;
    end
  endtask

  function automatic logic get_wait(input int sel);
    return (sel == 0) ? b0.waitrequest : b1.waitrequest;
  endfunction

  function automatic logic [31:0] get_rdata(input int sel);
    return (sel == 0) ? b0.readdata : b1.readdata;
  endfunction

  task automatic bus_write(input int sel, input logic [3:0] a, input logic [31:0] d, output int stalls);
    logic ok = 1'b0;
    stalls = 0;
    drive(sel, a, 1'b1, 1'b0, d);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!get_wait(sel)) begin ok = 1'b1; break; end
      stalls++;
    end
    if (!ok) begin checks++; $display("FAIL write_timeout: addr %0d still stalled after %0d cycles, required completion", a, stalls); end
    @(posedge clk); #1;
    drive(sel, 4'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic wr(input int sel, input logic [3:0] a, input logic [31:0] d);
    int s;
    bus_write(sel, a, d, s);
  endtask

  task automatic bus_read(input int sel, input logic [3:0] a, output logic [31:0] d, output int stalls);
    logic ok = 1'b0;
    stalls = 0;
    d = '0;
    drive(sel, a, 1'b0, 1'b1, 32'd0);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!get_wait(sel)) begin ok = 1'b1; d = get_rdata(sel); break; end
      stalls++;
    end
    if (!ok) begin checks++; $display("FAIL read_timeout: addr %0d still stalled after %0d cycles, required completion", a, stalls); end
    @(posedge clk); #1;
    drive(sel, 4'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic write_text(input int sel, input logic [127:0] v);
    for (int i = 0; i < 4; i++) wr(sel, 4'(i), v[32*i +: 32]);
  endtask

  task automatic write_key(input int sel, input logic [127:0] v);
    for (int i = 0; i < 4; i++) wr(sel, 4'(4 + i), v[32*i +: 32]);
  endtask

  task automatic read_text(input int sel, output logic [127:0] v, output int stalls);
    logic [31:0] d;
    int s;
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      bus_read(sel, 4'(i), d, s);
      v[32*i +: 32] = d;
      stalls += s;
    end
  endtask

  // Holds a STATUS read and counts cycles with busy set; returns the first non-busy STATUS.
  task automatic wait_idle(input int sel, output int cycles, output logic [31:0] status);
    logic ok = 1'b0;
    cycles = 0;
    status = '0;
    drive(sel, 4'd9, 1'b0, 1'b1, 32'd0);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      status = get_rdata(sel);
      if (!status[0]) begin ok = 1'b1; break; end
      cycles++;
    end
    if (!ok) begin checks++; $display("FAIL busy_timeout: busy still set after %0d cycles, required to fall", cycles); end
    @(posedge clk); #1;
    drive(sel, 4'd0, 1'b0, 1'b0, 32'd0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0]  d;
    logic [127:0] v;
    int s, st;
    bus_read(0, 4'd9, d, s);
    checks++; if (d !== 32'd0) $display("FAIL reset_status: got %h required %h", d, 32'd0); else passes++;
    checks++; if (irq0 !== 1'b0) $display("FAIL reset_irq: got %b required 0", irq0); else passes++;
    read_text(0, v, st);
    checks++; if ((s + st) !== 0) $display("FAIL reset_wait: got %0d stall cycles required 0", s + st); else passes++;
    checks++; if (v !== 128'd0) $display("FAIL reset_text: got %h required 0", v); else passes++;
    wr(0, 4'd4, 32'hDEADBEEF);
    bus_read(0, 4'd4, d, s);
    checks++; if (d !== 32'd0) $display("FAIL key_readback: got %h required 0", d); else passes++;
    wr(0, 4'd12, 32'h12345678);
    bus_read(0, 4'd12, d, s);
    checks++; if (d !== 32'd0) $display("FAIL unmapped_read: got %h required 0", d); else passes++;
  endtask

  task automatic test_encrypt_zero();
    logic [31:0]  st;
    logic [127:0] v, exp;
    int c, s;
    write_text(0, 128'd0);
    write_key(0, 128'd0);
    wr(0, 4'd8, 32'd1);
    wait_idle(0, c, st);
    checks++; if (c !== 24) $display("FAIL enc_zero_busy: got %0d cycles required 24", c); else passes++;
    checks++; if (st !== 32'd2) $display("FAIL enc_zero_status: got %h required 2", st); else passes++;
    checks++; if (irq0 !== 1'b1) $display("FAIL enc_zero_irq: got %b required 1", irq0); else passes++;
    exp = enc_model(128'd0, 128'd0, 12, 21);
    read_text(0, v, s);
    checks++; if (v !== exp) $display("FAIL enc_zero_text: got %h required %h", v, exp); else passes++;
  endtask

  task automatic test_round_trip();
    logic [31:0]  st;
    logic [127:0] ct, v, exp;
    int c, s;
    write_text(0, P);
    write_key(0, K);
    wr(0, 4'd8, 32'd1);
    wait_idle(0, c, st);
    exp = enc_model(P, K, 12, 21);
    read_text(0, ct, s);
    checks++; if (ct !== exp) $display("FAIL rt_cipher: got %h required %h", ct, exp); else passes++;
    write_text(0, ct);
    wr(0, 4'd8, 32'd3);
    wait_idle(0, c, st);
    checks++; if (c !== 35) $display("FAIL rt_dec_busy: got %0d cycles required 35", c); else passes++;
    read_text(0, v, s);
    checks++; if (v !== P) $display("FAIL rt_plain: got %h required %h", v, P); else passes++;
  endtask

  task automatic test_stall();
    logic [31:0]  d;
    logic [127:0] exp;
    int s;
    write_text(0, P2);
    write_key(0, K);
    wr(0, 4'd8, 32'd1);
    bus_read(0, 4'd9, d, s);
    checks++; if (d !== 32'd1 || s !== 0) $display("FAIL status_midop: got %h/%0d stalls required 1/0", d, s); else passes++;
    repeat (3) @(posedge clk);
    #1;
    exp = enc_model(P2, K, 12, 21);
    bus_read(0, 4'd0, d, s);
    checks++; if (s !== 20) $display("FAIL stall_cycles: got %0d required 20", s); else passes++;
    checks++; if (d !== exp[31:0]) $display("FAIL stall_data: got %h required %h", d, exp[31:0]); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [31:0]  st;
    logic [127:0] v;
    int c, s;
    write_text(0, P2);
    write_key(0, K);
    wr(0, 4'd8, 32'd1);
    bus_write(0, 4'd8, 32'd3, s);
    checks++; if (s !== 24) $display("FAIL b2b_ctrl_stall: got %0d required 24", s); else passes++;
    wait_idle(0, c, st);
    checks++; if (c !== 35) $display("FAIL b2b_dec_busy: got %0d required 35", c); else passes++;
    read_text(0, v, s);
    checks++; if (v !== P2) $display("FAIL b2b_plain: got %h required %h", v, P2); else passes++;
  endtask

  task automatic test_reset_mid();
    logic [31:0]  d, st;
    logic [127:0] v, exp;
    int c, s;
    write_text(0, P);
    write_key(0, K);
    wr(0, 4'd8, 32'd1);
    repeat (11) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus_read(0, 4'd9, d, s);
    checks++; if (d !== 32'd0 || s !== 0) $display("FAIL midreset_status: got %h/%0d stalls required 0/0", d, s); else passes++;
    checks++; if (irq0 !== 1'b0) $display("FAIL midreset_irq: got %b required 0", irq0); else passes++;
    read_text(0, v, s);
    checks++; if (v !== 128'd0) $display("FAIL midreset_text: got %h required 0", v); else passes++;
    write_text(0, P);
    write_key(0, K);
    wr(0, 4'd8, 32'd1);
    wait_idle(0, c, st);
    exp = enc_model(P, K, 12, 21);
    read_text(0, v, s);
    checks++; if (c !== 24 || v !== exp) $display("FAIL midreset_fresh: got %h/%0d cycles required %h/24", v, c, exp); else passes++;
  endtask

  task automatic test_one_round();
    logic [31:0]  st, d;
    logic [127:0] v, exp;
    int c, s;
    write_text(1, P);
    write_key(1, K);
    wr(1, 4'd8, 32'd1);
    wait_idle(1, c, st);
    checks++; if (c !== 2) $display("FAIL r1_enc_busy: got %0d required 2", c); else passes++;
    exp = enc_model(P, K, 1, 1);
    read_text(1, v, s);
    checks++; if (v !== exp) $display("FAIL r1_cipher: got %h required %h", v, exp); else passes++;
    wr(1, 4'd8, 32'd3);
    wait_idle(1, c, st);
    checks++; if (c !== 2) $display("FAIL r1_dec_busy: got %0d required 2", c); else passes++;
    checks++; if (st !== 32'd2 || irq1 !== 1'b1) $display("FAIL r1_done: got %h/irq %b required 2/1", st, irq1); else passes++;
    read_text(1, v, s);
    checks++; if (v !== P) $display("FAIL r1_plain: got %h required %h", v, P); else passes++;
    wr(1, 4'd8, 32'd4);
    bus_read(1, 4'd9, d, s);
    checks++; if (d !== 32'd0 || irq1 !== 1'b0) $display("FAIL r1_clear_done: got %h/irq %b required 0/0", d, irq1); else passes++;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 4'd0, 1'b0, 1'b0, 32'd0);
    drive(1, 4'd0, 1'b0, 1'b0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_encrypt_zero();
    test_round_trip();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_one_round();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
